// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signals between the hazard/stall controller and the datapath.
// The datapath drives hazard inputs (master); the controller returns the stall controls (slave).
interface hazard_stall_controller_if;
  logic [4:0]  IFID_Rs;
  logic [4:0]  IFID_Rt;
  logic        IFID_UsesRt;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_Rt;
  logic        BranchTaken;
  logic        DivStart;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        IDEXBubble;
  logic        DivBusy;
  logic        DivDone;
  logic [15:0] StallCount;

  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt, BranchTaken, DivStart,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, DivBusy, DivDone, StallCount
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt, BranchTaken, DivStart,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, DivBusy, DivDone, StallCount
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-flush / multi-cycle divide stall controller with a saturating stall counter.
// state    | meaning
// RUN      | normal issue; load-use stalls one cycle, taken branch flushes IF/ID
// DIV_WAIT | divider occupies the pipeline for DIV_CYCLES cycles, all inputs ignored
module hazard_stall_controller #(
  parameter int DIV_CYCLES = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_stall_controller_if.slave  hsc
);

  typedef enum logic [0:0] {RUN, DIV_WAIT} state_t;

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, div_busy, div_done;

  assign load_use = hsc.IDEX_MemRead && (hsc.IDEX_Rt != 5'd0) &&
                    ((hsc.IDEX_Rt == hsc.IFID_Rs) ||
                     (hsc.IFID_UsesRt && (hsc.IDEX_Rt == hsc.IFID_Rt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      div_cnt_q   <= 6'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    div_busy    = 1'b0;
    div_done    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (load_use) begin
          // Load-use wins over a taken branch; the branch re-resolves after the stall.
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (hsc.BranchTaken) begin
          ifid_flush  = 1'b1;
        end
        if (hsc.DivStart) begin
          state_d   = DIV_WAIT;
          div_cnt_d = DIV_LOAD;
        end
      end
      DIV_WAIT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        div_busy    = 1'b1;
        if (div_cnt_q == 6'd0) begin
          div_done = 1'b1;
          state_d  = RUN;
        end else begin
          div_cnt_d = div_cnt_q - 6'd1;
        end
      end
      default: state_d = RUN;
    endcase

    // Reset overrides the outputs combinationally so an aborted divide never pulses DivDone.
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      div_busy    = 1'b0;
      div_done    = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  assign hsc.PCWrite    = pc_write;
  assign hsc.IFIDWrite  = ifid_write;
  assign hsc.IFIDFlush  = ifid_flush;
  assign hsc.IDEXBubble = idex_bubble;
  assign hsc.DivBusy    = div_busy;
  assign hsc.DivDone    = div_done;
  assign hsc.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: load-use, rt source, branch, divide, reset abort, saturation.
module tb_hazard_stall_controller;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   busy_cycles;
  int   done_cycles;
  int   done_at;

  hazard_stall_controller_if hif ();

  hazard_stall_controller #(.DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .hsc (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hif.IFID_Rs      = 5'd0;
    hif.IFID_Rt      = 5'd0;
    hif.IFID_UsesRt  = 1'b0;
    hif.IDEX_MemRead = 1'b0;
    hif.IDEX_Rt      = 5'd0;
    hif.BranchTaken  = 1'b0;
    hif.DivStart     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pcw"},   hif.PCWrite,    0);
    check_eq({tag, "_ifw"},   hif.IFIDWrite,  0);
    check_eq({tag, "_flush"}, hif.IFIDFlush,  1);
    check_eq({tag, "_bub"},   hif.IDEXBubble, 1);
    check_eq({tag, "_busy"},  hif.DivBusy,    0);
    check_eq({tag, "_done"},  hif.DivDone,    0);
    check_eq({tag, "_cnt"},   hif.StallCount, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    clear_inputs();
    repeat (2) step();
    #1;
    check_reset_outputs("rst");

    rst = 1'b1;
    #1;
    check_eq("run_pcw",   hif.PCWrite,   1);
    check_eq("run_ifw",   hif.IFIDWrite, 1);
    check_eq("run_flush", hif.IFIDFlush, 0);
    check_eq("run_bub",   hif.IDEXBubble, 0);

    // load-use on rs
    hif.IDEX_MemRead = 1'b1; hif.IDEX_Rt = 5'd5; hif.IFID_Rs = 5'd5;
    #1;
    check_eq("lu_pcw",   hif.PCWrite,    0);
    check_eq("lu_ifw",   hif.IFIDWrite,  0);
    check_eq("lu_bub",   hif.IDEXBubble, 1);
    check_eq("lu_flush", hif.IFIDFlush,  0);
    check_eq("lu_cnt0",  hif.StallCount, 0);
    step();
    clear_inputs();
    #1;
    check_eq("lu_cnt1",  hif.StallCount, 1);
    check_eq("lu_after_pcw", hif.PCWrite, 1);

    hif.IDEX_MemRead = 1'b1; hif.IDEX_Rt = 5'd0; hif.IFID_Rs = 5'd0;
    #1;
    check_eq("r0_pcw", hif.PCWrite, 1);
    step();
    check_eq("r0_cnt", hif.StallCount, 1);

    // rt source
    hif.IDEX_MemRead = 1'b1; hif.IDEX_Rt = 5'd7; hif.IFID_Rt = 5'd7;
    hif.IFID_Rs = 5'd3; hif.IFID_UsesRt = 1'b1;
    #1;
    check_eq("rt_use_pcw", hif.PCWrite, 0);
    check_eq("rt_use_bub", hif.IDEXBubble, 1);
    step();
    check_eq("rt_use_cnt", hif.StallCount, 2);
    hif.IFID_UsesRt = 1'b0;
    #1;
    check_eq("rt_nouse_pcw", hif.PCWrite, 1);
    step();
    check_eq("rt_nouse_cnt", hif.StallCount, 2);

    // branch
    clear_inputs();
    hif.BranchTaken = 1'b1;
    #1;
    check_eq("br_flush", hif.IFIDFlush, 1);
    check_eq("br_pcw",   hif.PCWrite,   1);
    check_eq("br_ifw",   hif.IFIDWrite, 1);
    check_eq("br_bub",   hif.IDEXBubble, 0);
    hif.IDEX_MemRead = 1'b1; hif.IDEX_Rt = 5'd9; hif.IFID_Rs = 5'd9;
    #1;
    check_eq("brlu_flush", hif.IFIDFlush, 0);
    check_eq("brlu_pcw",   hif.PCWrite,   0);
    check_eq("brlu_bub",   hif.IDEXBubble, 1);
    step();
    check_eq("brlu_cnt", hif.StallCount, 3);
    clear_inputs();

    // divide
    do_reset();
    hif.DivStart = 1'b1;
    #1;
    check_eq("ds_pcw",  hif.PCWrite, 1);
    check_eq("ds_busy", hif.DivBusy, 0);
    busy_cycles = 0;
    done_cycles = 0;
    done_at     = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 1) hif.DivStart = 1'b0;
      if (i == 5) begin
        hif.BranchTaken = 1'b1; hif.DivStart = 1'b1;
        hif.IDEX_MemRead = 1'b1; hif.IDEX_Rt = 5'd4; hif.IFID_Rs = 5'd4;
      end
      if (i == 6) clear_inputs();
      #1;
      if (hif.DivBusy) busy_cycles++;
      if (hif.DivDone) begin
        done_cycles++;
        done_at = i;
      end
      if (i == 5) begin
        check_eq("dw_mid_flush", hif.IFIDFlush, 0);
        check_eq("dw_mid_pcw",   hif.PCWrite,   0);
        check_eq("dw_mid_cnt",   hif.StallCount, 4);
      end
    end
    check_eq("div_busy_cycles", busy_cycles, 32);
    check_eq("div_done_cycles", done_cycles, 1);
    check_eq("div_done_at",     done_at,     32);
    step();
    check_eq("div_end_busy", hif.DivBusy, 0);
    check_eq("div_end_done", hif.DivDone, 0);
    check_eq("div_end_pcw",  hif.PCWrite, 1);
    check_eq("div_end_cnt",  hif.StallCount, 32);

    // reset abort in 10th wait cycle
    hif.DivStart = 1'b1;
    #1;
    for (int i = 1; i <= 10; i++) begin
      step();
      hif.DivStart = 1'b0;
    end
    #1;
    check_eq("ab_busy_pre", hif.DivBusy, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    done_cycles = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (hif.DivDone) done_cycles++;
    end
    check_eq("abort_no_done", done_cycles, 0);
    rst = 1'b1;
    #1;
    check_eq("abort_rel_pcw",  hif.PCWrite, 1);
    check_eq("abort_rel_busy", hif.DivBusy, 0);
    step();
    check_eq("abort_run_busy", hif.DivBusy, 0);
    check_eq("abort_run_cnt",  hif.StallCount, 0);

    // saturation
    hif.IDEX_MemRead = 1'b1; hif.IDEX_Rt = 5'd2; hif.IFID_Rs = 5'd2;
    repeat (65534) step();
    check_eq("sat_fffe", hif.StallCount, 16'hFFFE);
    step();
    check_eq("sat_ffff", hif.StallCount, 16'hFFFF);
    repeat (5) step();
    check_eq("sat_hold", hif.StallCount, 16'hFFFF);
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
